// File: rtl/camera_stream_ctrl_pkg.sv
// Shared types and constants for the camera stream controller: FSM states,
// register map, CTRL/STATUS bit positions and pixel-counter width.
package camera_stream_ctrl_pkg;

    localparam int unsigned DataW   = 24;
    localparam int unsigned PixCntW = 21;

    typedef enum logic [1:0] {
        StIdle,
        StWaitSop,
        StPass,
        StDrain
    } cam_state_e;

    localparam logic [2:0] AddrCtrl       = 3'd0;
    localparam logic [2:0] AddrStatus     = 3'd1;
    localparam logic [2:0] AddrFrameCount = 3'd2;
    localparam logic [2:0] AddrLastPix    = 3'd3;
    localparam logic [2:0] AddrDropped    = 3'd4;

    localparam int unsigned CtrlRun    = 0;
    localparam int unsigned CtrlSingle = 1;
    localparam int unsigned CtrlErrClr = 2;

    localparam int unsigned StatPass = 0;
    localparam int unsigned StatOvr  = 1;
    localparam int unsigned StatUnd  = 2;
    localparam int unsigned StatBusy = 3;

endpackage

// File: rtl/camera_stream_ctrl_if.sv
// Avalon-ST sink/source and Avalon-MM slave signals of the camera stream controller.
interface camera_stream_ctrl_if;
    import camera_stream_ctrl_pkg::*;

    logic [DataW-1:0] snk_data;
    logic             snk_valid;
    logic             snk_sop;
    logic             snk_eop;
    logic             snk_ready;

    logic [DataW-1:0] src_data;
    logic             src_valid;
    logic             src_sop;
    logic             src_eop;
    logic             src_ready;

    logic [2:0]       avs_address;
    logic             avs_read;
    logic             avs_write;
    logic [31:0]      avs_writedata;
    logic [31:0]      avs_readdata;

    modport master (
        output snk_data, snk_valid, snk_sop, snk_eop, src_ready,
               avs_address, avs_read, avs_write, avs_writedata,
        input  snk_ready, src_data, src_valid, src_sop, src_eop, avs_readdata
    );

    modport slave (
        input  snk_data, snk_valid, snk_sop, snk_eop, src_ready,
               avs_address, avs_read, avs_write, avs_writedata,
        output snk_ready, src_data, src_valid, src_sop, src_eop, avs_readdata
    );

endinterface

// File: rtl/cam_ctrl_regs.sv
// Avalon-MM register bank: CTRL, sticky error flags, frame/drop counters,
// registered read data with one cycle of latency.
module cam_ctrl_regs
    import camera_stream_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    input  cam_state_e         state,
    input  logic               frame_end,
    input  logic [PixCntW-1:0] last_pix,
    input  logic               ovr_set,
    input  logic               und_set,
    input  logic               drop_inc,
    output logic               run,
    output logic               single
);

    logic               run_q, single_q, ovr_q, und_q;
    logic [31:0]        frame_cnt_q;
    logic [PixCntW-1:0] last_pix_q;
    logic [15:0]        dropped_q;
    logic [31:0]        rdata_q, rdata_d;
    logic [3:0]         status;
    logic               ctrl_wr, err_clr;
    logic               unused_wdata;

    assign ctrl_wr      = avs_write && (avs_address == AddrCtrl);
    assign err_clr      = ctrl_wr && avs_writedata[CtrlErrClr];
    assign unused_wdata = ^avs_writedata[31:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q       <= 1'b0;
            single_q    <= 1'b0;
            ovr_q       <= 1'b0;
            und_q       <= 1'b0;
            frame_cnt_q <= '0;
            last_pix_q  <= '0;
            dropped_q   <= '0;
            rdata_q     <= '0;
        end else begin
            if (ctrl_wr) begin
                run_q    <= avs_writedata[CtrlRun];
                single_q <= avs_writedata[CtrlSingle];
            end
            // A finished single capture disarms, even against a same-cycle CTRL write
            if (frame_end && single_q) begin
                run_q    <= 1'b0;
                single_q <= 1'b0;
            end
            ovr_q <= ovr_set | (ovr_q & ~err_clr);
            und_q <= und_set | (und_q & ~err_clr);
            if (frame_end) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
                last_pix_q  <= last_pix;
            end
            if (drop_inc && (dropped_q != 16'hFFFF)) begin
                dropped_q <= dropped_q + 16'd1;
            end
            if (avs_read) begin
                rdata_q <= rdata_d;
            end
        end
    end

    always_comb begin
        status           = '0;
        status[StatPass] = (state == StPass);
        status[StatOvr]  = ovr_q;
        status[StatUnd]  = und_q;
        status[StatBusy] = (state != StIdle);
    end

    always_comb begin
        rdata_d = '0;
        case (avs_address)
            AddrCtrl:       rdata_d = {30'd0, single_q, run_q};
            AddrStatus:     rdata_d = {28'd0, status};
            AddrFrameCount: rdata_d = frame_cnt_q;
            AddrLastPix:    rdata_d = {{(32 - PixCntW){1'b0}}, last_pix_q};
            AddrDropped:    rdata_d = {16'd0, dropped_q};
            default:        rdata_d = '0;
        endcase
    end

    assign avs_readdata = rdata_q;
    assign run          = run_q;
    assign single       = single_q;

endmodule

// File: rtl/camera_stream_ctrl.sv
// Camera stream gate: forwards whole video frames while armed, enforces the
// frame size with a forced eop and drain, and tracks errors/drops.
module camera_stream_ctrl
    import camera_stream_ctrl_pkg::*;
#(
    parameter int unsigned VIDEO_W = 1280,
    parameter int unsigned VIDEO_H = 720
) (
    input logic                clk,
    input logic                reset_n,
    camera_stream_ctrl_if.slave bus
);

    localparam logic [PixCntW-1:0] FramePix = PixCntW'(VIDEO_W * VIDEO_H);

    cam_state_e         state_q, state_d;
    logic [PixCntW-1:0] pix_q, pix_d, pix_inc;
    logic               is_video_sop, force_eop;
    logic               snk_rdy, src_vld, src_sop, src_eop;
    logic               frame_end, ovr_set, und_set, drop_inc;
    logic               run, single;

    assign bus.src_data = bus.snk_data;
    assign is_video_sop = bus.snk_sop && (bus.snk_data[3:0] == 4'h0);
    // sop beats carry packet type, not pixels, so they never count
    assign pix_inc      = pix_q + {{(PixCntW - 1){1'b0}}, ~bus.snk_sop};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        snk_rdy   = 1'b1;
        src_vld   = 1'b0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
        force_eop = 1'b0;
        frame_end = 1'b0;
        ovr_set   = 1'b0;
        und_set   = 1'b0;
        drop_inc  = 1'b0;
        unique case (state_q)
            StIdle: begin
                drop_inc = bus.snk_valid && is_video_sop;
                if (run) state_d = StWaitSop;
            end
            StWaitSop: begin
                if (!run) begin
                    state_d = StIdle;
                end else if (bus.snk_valid && is_video_sop) begin
                    src_vld = 1'b1;
                    snk_rdy = bus.src_ready;
                    src_sop = 1'b1;
                    src_eop = bus.snk_eop;
                    if (bus.src_ready) begin
                        state_d = StPass;
                        pix_d   = '0;
                    end
                end
            end
            StPass: begin
                src_vld   = bus.snk_valid;
                snk_rdy   = bus.src_ready;
                src_sop   = bus.snk_sop;
                force_eop = !bus.snk_eop && (pix_inc == FramePix);
                src_eop   = bus.snk_eop || force_eop;
                if (bus.snk_valid && bus.src_ready) begin
                    pix_d = is_video_sop ? '0 : pix_inc;
                    if (bus.snk_eop) begin
                        frame_end = 1'b1;
                        und_set   = (pix_d < FramePix);
                        state_d   = (run && !single) ? StWaitSop : StIdle;
                    end else if (force_eop) begin
                        frame_end = 1'b1;
                        ovr_set   = 1'b1;
                        state_d   = StDrain;
                    end
                end
            end
            StDrain: begin
                if (bus.snk_valid && bus.snk_eop) begin
                    state_d = (run && !single) ? StWaitSop : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.snk_ready = snk_rdy;
    assign bus.src_valid = src_vld;
    assign bus.src_sop   = src_sop;
    assign bus.src_eop   = src_eop;

    cam_ctrl_regs u_regs (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (bus.avs_address),
        .avs_read      (bus.avs_read),
        .avs_write     (bus.avs_write),
        .avs_writedata (bus.avs_writedata),
        .avs_readdata  (bus.avs_readdata),
        .state         (state_q),
        .frame_end     (frame_end),
        .last_pix      (pix_d),
        .ovr_set       (ovr_set),
        .und_set       (und_set),
        .drop_inc      (drop_inc),
        .run           (run),
        .single        (single)
    );

endmodule
